// File: rtl/cpu_mem_pkg.sv
// Shared memory-port types for the 16-bit pipeline: arbiter states, port
// owner encoding, bus width defaults and the IF/DM grant rule.
package cpu_mem_pkg;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  // DM wins unless it held the previous grant and IF is waiting, so sustained
  // contention alternates. Only meaningful when at least one side is pending.
  function automatic owner_t pick_owner(input logic if_pend, input logic dm_pend,
                                        input owner_t last);
    if (dm_pend && !(last == OWN_DM && if_pend))
      return OWN_DM;
    return OWN_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (IF) and data (DM): one
// transaction in flight, sequenced issue -> fixed-latency wait -> response.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_valid,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_valid,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  stall_if,
  output logic                  stall_mem,
  output logic                  busy
);

  state_t     state;
  owner_t     owner;
  owner_t     last_grant;
  logic [2:0] cnt;
  logic       lat_we;

  logic   if_pend;
  logic   dm_pend;
  logic   any_pend;
  owner_t nxt_owner;

  // In RESP the served side still holds req high, so it must not re-win.
  always_comb begin
    if_pend   = if_req & ~(state == RESP && owner == OWN_IF);
    dm_pend   = dm_req & ~(state == RESP && owner == OWN_DM);
    any_pend  = if_pend | dm_pend;
    nxt_owner = pick_owner(if_pend, dm_pend, last_grant);
  end

  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = dm_req & ~dm_valid;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      last_grant <= OWN_IF;
      cnt        <= 3'd0;
      lat_we     <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_valid   <= 1'b0;
      dm_valid   <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
      case (state)
        IDLE, RESP: begin
          if (any_pend) begin
            owner      <= nxt_owner;
            last_grant <= nxt_owner;
            mem_en     <= 1'b1;
            if (nxt_owner == OWN_DM) begin
              lat_we    <= dm_we;
              mem_we    <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
            end else begin
              lat_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
            end
            state <= ISSUE;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          cnt   <= 3'(MEM_LATENCY - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            // Valid/rdata registers form the response stage shown during RESP.
            if (owner == OWN_IF) begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end else begin
              dm_valid <= 1'b1;
              dm_rdata <= lat_we ? '0 : mem_rdata;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiters (latency 2, 1, 7) on shared stimulus, each
// with a memory model returning addr ^ 0xA5B5 exactly LAT cycles after mem_en.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [15:0] dm_addr = '0;
  logic [15:0] dm_wdata = '0;

  logic [15:0] if_rdata_a [3];
  logic        if_valid_a [3];
  logic [15:0] dm_rdata_a [3];
  logic        dm_valid_a [3];
  logic        mem_en_a [3];
  logic        mem_we_a [3];
  logic [15:0] mem_addr_a [3];
  logic [15:0] mem_wdata_a [3];
  logic [15:0] mem_rdata_a [3];
  logic        stall_if_a [3];
  logic        stall_mem_a [3];
  logic        busy_a [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gd
    localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 7;
    logic [7:0]  vp;
    logic [15:0] dp [8];

    mem_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MEM_LATENCY(L)) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_a[g]), .if_valid(if_valid_a[g]),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata_a[g]), .dm_valid(dm_valid_a[g]),
      .mem_en(mem_en_a[g]), .mem_we(mem_we_a[g]), .mem_addr(mem_addr_a[g]),
      .mem_wdata(mem_wdata_a[g]), .mem_rdata(mem_rdata_a[g]),
      .stall_if(stall_if_a[g]), .stall_mem(stall_mem_a[g]), .busy(busy_a[g])
    );

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        vp <= '0;
      end else begin
        vp    <= {vp[6:0], mem_en_a[g]};
        dp[0] <= mem_addr_a[g] ^ 16'hA5B5;
        for (int i = 1; i < 8; i++) dp[i] <= dp[i-1];
      end
    end

    assign mem_rdata_a[g] = vp[L-1] ? dp[L-1] : 16'hDEAD;
  end

  typedef struct { int c; logic we; logic [15:0] addr; logic [15:0] wdata; } en_t;
  typedef struct { int c; logic dm; logic [15:0] d_if; logic [15:0] d_dm; } v_t;

  int          cyc = -1;
  en_t         en_log [$];
  v_t          v_log [$];
  logic        st_if [32];
  int          first_v [3];
  logic [15:0] first_d [3];
  int          viol = 0;
  int          errors = 0;
  int          checks = 0;
  int          if_left = 0;
  int          dm_left = 0;

  always @(negedge clk) begin
    if (cyc < 0) begin
      en_log.delete();
      v_log.delete();
      for (int g = 0; g < 3; g++) first_v[g] = -1;
    end else begin
      if (mem_en_a[0])
        en_log.push_back('{cyc, mem_we_a[0], mem_addr_a[0], mem_wdata_a[0]});
      if (if_valid_a[0] || dm_valid_a[0])
        v_log.push_back('{cyc, dm_valid_a[0], if_rdata_a[0], dm_rdata_a[0]});
      if (cyc < 32) st_if[cyc] = stall_if_a[0];
      for (int g = 0; g < 3; g++) begin
        if (first_v[g] < 0 && (if_valid_a[g] || dm_valid_a[g])) begin
          first_v[g] = cyc;
          first_d[g] = if_valid_a[g] ? if_rdata_a[g] : dm_rdata_a[g];
        end
      end
    end
    for (int g = 0; g < 3; g++)
      if ((!if_valid_a[g] && if_rdata_a[g] != 16'h0) || (!dm_valid_a[g] && dm_rdata_a[g] != 16'h0))
        viol++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic v_t v_at(input int i);
    v_t r;
    r = '{-1, 1'b0, 16'h0, 16'h0};
    if (i < v_log.size()) r = v_log[i];
    return r;
  endfunction

  function automatic en_t en_at(input int i);
    en_t r;
    r = '{-1, 1'b0, 16'h0, 16'h0};
    if (i < en_log.size()) r = en_log[i];
    return r;
  endfunction

  // Advance one cycle; requesters drop req the cycle after their last valid.
  task automatic step();
    logic iv, dv;
    iv = if_valid_a[0];
    dv = dm_valid_a[0];
    @(posedge clk);
    #2;
    cyc = cyc + 1;
    if (iv && if_left > 0) begin
      if_left--;
      if (if_left == 0) if_req = 1'b0;
    end
    if (dv && dm_left > 0) begin
      dm_left--;
      if (dm_left == 0) dm_req = 1'b0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic reset_on();
    rst = 1'b1;
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    if_left = 0; dm_left = 0;
    cyc = -1;
    repeat (2) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    // Lone fetch, preceded by reset-state checks
    reset_on();
    chk("reset_ctrl", {mem_en_a[0], mem_we_a[0], if_valid_a[0], dm_valid_a[0], busy_a[0]}, 5'b0);
    chk("reset_data", {mem_addr_a[0], mem_wdata_a[0], if_rdata_a[0], dm_rdata_a[0]}, 64'h0);
    if_req = 1'b1;
    #1;
    chk("reset_stall_if", stall_if_a[0], 1'b1);
    chk("reset_stall_mem", stall_mem_a[0], 1'b0);
    if_req = 1'b0;
    #1;
    rst = 1'b0;
    cyc = 0; if_req = 1'b1; if_addr = 16'h0010; if_left = 1;
    run(8);
    chk("fetch_en_cyc", en_at(0).c, 1);
    chk("fetch_en_addr", en_at(0).addr, 16'h0010);
    chk("fetch_en_we", en_at(0).we, 1'b0);
    chk("fetch_v_cyc", v_at(0).c, 4);
    chk("fetch_v_owner", v_at(0).dm, 1'b0);
    chk("fetch_rdata", v_at(0).d_if, 16'hA5A5);
    chk("fetch_other_rdata", v_at(0).d_dm, 16'h0);
    chk("fetch_txn_count", v_log.size(), 1);
    chk("fetch_stall_trace", {st_if[4], st_if[3], st_if[2], st_if[1], st_if[0]}, 5'b01111);

    // Same requester back-to-back: one IDLE cycle between transactions
    reset_on();
    rst = 1'b0;
    cyc = 0; if_req = 1'b1; if_addr = 16'h0010; if_left = 2;
    run(12);
    chk("refetch_v0_cyc", v_at(0).c, 4);
    chk("refetch_v1_cyc", v_at(1).c, 9);

    // Simultaneous requests after reset: DM first, IF issue with no gap
    reset_on();
    rst = 1'b0;
    cyc = 0;
    if_req = 1'b1; if_addr = 16'h0040; if_left = 1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0200; dm_left = 1;
    run(12);
    chk("simul_first_owner", v_at(0).dm, 1'b1);
    chk("simul_dm_cyc", v_at(0).c, 4);
    chk("simul_dm_rdata", v_at(0).d_dm, 16'hA7B5);
    chk("simul_if_issue_cyc", en_at(1).c, 5);
    chk("simul_if_issue_addr", en_at(1).addr, 16'h0040);
    chk("simul_if_cyc", v_at(1).c, 8);
    chk("simul_if_rdata", v_at(1).d_if, 16'hA5F5);

    // Continuous contention: strict alternation at one per 4 cycles
    reset_on();
    rst = 1'b0;
    cyc = 0;
    if_req = 1'b1; if_addr = 16'h0040; if_left = 3;
    dm_req = 1'b1; dm_addr = 16'h0200; dm_left = 3;
    run(28);
    chk("contend_count", v_log.size(), 6);
    chk("contend_owners", {v_at(5).dm, v_at(4).dm, v_at(3).dm, v_at(2).dm, v_at(1).dm, v_at(0).dm}, 6'b010101);
    for (int i = 0; i < 6; i++) chk($sformatf("contend_cyc%0d", i), v_at(i).c, 4 + 4 * i);

    // Store
    reset_on();
    rst = 1'b0;
    cyc = 0;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0300; dm_wdata = 16'h1234; dm_left = 1;
    run(8);
    chk("store_en_cyc", en_at(0).c, 1);
    chk("store_en_we", en_at(0).we, 1'b1);
    chk("store_en_addr", en_at(0).addr, 16'h0300);
    chk("store_en_wdata", en_at(0).wdata, 16'h1234);
    chk("store_v_cyc", v_at(0).c, 4);
    chk("store_rdata", v_at(0).d_dm, 16'h0);

    // Reset in the middle of WAIT, then a full-latency restart
    reset_on();
    rst = 1'b0;
    cyc = 0; if_req = 1'b1; if_addr = 16'h0010; if_left = 1;
    run(2);
    rst = 1'b1;
    #1;
    chk("midrst_ctrl", {mem_en_a[0], mem_we_a[0], if_valid_a[0], dm_valid_a[0], busy_a[0]}, 5'b0);
    chk("midrst_data", {mem_addr_a[0], mem_wdata_a[0], if_rdata_a[0], dm_rdata_a[0]}, 64'h0);
    repeat (3) begin
      @(posedge clk);
      #2;
    end
    chk("midrst_no_valid", v_log.size(), 0);
    cyc = -1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    cyc = 0;
    run(8);
    chk("midrst_restart_cyc", v_at(0).c, 4);
    chk("midrst_restart_rdata", v_at(0).d_if, 16'hA5A5);

    // Latency sweep; address changes during WAIT must not reach mem_addr
    reset_on();
    rst = 1'b0;
    cyc = 0; if_req = 1'b1; if_addr = 16'h0010;
    run(3);
    if_addr = 16'h0777;
    run(2);
    chk("lat7_addr_hold", mem_addr_a[2], 16'h0010);
    run(6);
    if_req = 1'b0;
    run(2);
    chk("lat2_v_cyc", first_v[0], 4);
    chk("lat1_v_cyc", first_v[1], 3);
    chk("lat7_v_cyc", first_v[2], 9);
    chk("lat7_rdata", first_d[2], 16'hA5A5);

    chk("rdata_zero_when_idle", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Arbitrates one single-port instruction/data memory between the fetch stage (IF) and the data-memory stage (MEM) of the 16-bit pipelined processor.
- Serialises accesses so that exactly one transaction is outstanding at a time, and sequences each one through issue, fixed-latency wait and response.
- Generates the stall requests the hazard logic folds into the PC, IF/ID and EX/MEM stall controls.

## Interface
Parameters:
- ADDR_WIDTH, 16, memory address width
- DATA_WIDTH, 16, memory data width
- MEM_LATENCY, 2, cycles from mem_en to valid mem_rdata; legal range 1..7

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held high until if_valid
- if_addr  in  ADDR_WIDTH  fetch address
- if_rdata  out  DATA_WIDTH  fetched instruction, valid with if_valid
- if_valid  out  1  one-cycle fetch completion pulse
- dm_req  in  1  data request; held high until dm_valid
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_WIDTH  data address
- dm_wdata  in  DATA_WIDTH  store data
- dm_rdata  out  DATA_WIDTH  load data, valid with dm_valid
- dm_valid  out  1  one-cycle data completion pulse (loads and stores)
- mem_en  out  1  memory access strobe, one cycle per transaction
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after mem_en
- stall_if  out  1  if_req & ~if_valid
- stall_mem  out  1  dm_req & ~dm_valid
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**: if any request is pending, grant one, latch its owner, addr, we and wdata, then go to ISSUE. Otherwise stay in IDLE.
- **Grant rule**: DM has priority. Exception: when the previous grant was DM and if_req is high, IF wins. This alternates under continuous contention, so neither side starves.
- **ISSUE**: mem_en=1 and mem_we/mem_addr/mem_wdata are driven from the latched registers, all registered. Load cnt = MEM_LATENCY-1, then go to WAIT.
- **WAIT**:
  - When cnt==0: capture mem_rdata into the response register (0 for stores) and go to RESP.
  - Otherwise: decrement cnt.
- **RESP**: pulse the owner's valid, with rdata from the response register.
  - The served requester's req is masked this cycle, because it is still high.
  - The other requester is arbitrated as in IDLE. If it is pending, go straight to ISSUE; otherwise go to IDLE.
- Request attributes are sampled only at grant. Changing addr/wdata mid-transaction has no effect.
- A requester that drops req before its valid is a protocol violation. The transaction still completes and valid still pulses.
- stall_if and stall_mem are combinational from req and valid.
- Width rules:
  - cnt is 3 bits.
  - if_rdata and dm_rdata are 0 whenever their valid is low.
  - The non-owner's rdata is always 0.

## Timing
- Reset: state=IDLE, cnt=0, last-grant=IF. All outputs are 0: mem_en, mem_we, mem_addr, mem_wdata, if_valid, dm_valid, if_rdata, dm_rdata, busy. The stall outputs follow req.
- Reset asserted mid-transaction: abandon immediately and return to IDLE. No valid pulse is produced.
- Request sampled in cycle 0 → ISSUE in cycle 1 → WAIT for MEM_LATENCY cycles → RESP (valid) in cycle MEM_LATENCY+2. With MEM_LATENCY=2, valid arrives in cycle 4.
- Throughput:
  - One transaction per MEM_LATENCY+2 cycles when both sides are continuously requesting, with no IDLE gap.
  - A single requester re-requesting after its valid incurs one IDLE cycle.
- Simultaneous if_req and dm_req in IDLE after reset: DM is granted first.

## Structure
- Shared package cpu_mem_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, RESP}
  - owner enum {OWN_IF, OWN_DM}
  - ADDR_WIDTH/DATA_WIDTH defaults, shared with the pipeline top
- Single module. No sub-module is needed; the latency counter stays inline.

## Test plan
- **Lone fetch**: LAT=2, if_req=1, if_addr=0x0010, mem returns 0xA5A5 in cycle 3 → mem_en in cycle 1 with addr 0x0010; if_valid=1 and if_rdata=0xA5A5 in cycle 4; stall_if high in cycles 0–3.
- **Simultaneous requests**: both requests after reset, dm load at 0x0200 → DM is served first (dm_valid in cycle 4). The IF ISSUE follows in cycle 5 with no IDLE gap, and if_valid arrives in cycle 8.
- **Continuous contention**: both requesters re-request continuously for 6 transactions → grants alternate DM, IF, DM, IF, DM, IF.
- **Store**: dm_we=1, addr 0x0300, wdata 0x1234 → mem_en=1, mem_we=1 with matching addr/wdata in cycle 1; dm_valid in cycle 4 with dm_rdata=0.
- **Reset mid-WAIT**: assert rst in cycle 2 → all outputs are 0 the same cycle, and no valid pulse is produced. A request after reset release restarts with full latency.
- **Latency sweep**: LAT=1 and LAT=7 → valid arrives in cycle 3 and cycle 9 respectively. Changing addr during WAIT does not alter mem_addr.
